// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and a clog2 helper.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_MULTU = 4'b1010;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((32'sd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the pipeline and alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, sel, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, ovf, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, sel, out_ready,
        output in_ready, out_valid, result, result_hi, zero, ovf, busy
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier retiring MUL_STEP multiplier bits per cycle.
// done_o is high during the last step; prod_o then already includes that step.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CW    = clog2(STEPS);
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    logic               run_q, run_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] partial_s;
    logic               last_s;

    assign last_s = (cnt_q == LAST_CNT);
    assign done_o = run_q && last_s;
    assign prod_o = acc_q + partial_s;

    // Partial product of the multiplicand with the low MUL_STEP multiplier bits.
    always_comb begin
        partial_s = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) begin
                partial_s = partial_s + (mcand_q << i);
            end else begin
                partial_s = partial_s;
            end
        end
    end

    // Capture on start, then accumulate one slice per cycle until the counter wraps.
    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start_i) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
        end else if (run_q) begin
            acc_d    = acc_q + partial_s;
            mcand_d  = mcand_q << MUL_STEP;
            mplier_d = mplier_q >> MUL_STEP;
            if (last_s) begin
                run_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Multiplier datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked MIPS-style ALU with registered result/flags and optional iterative MULTU.
// Define ALU_SEQ_MULT_EN to build the multiplier; otherwise sel=1010 is an unknown code.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);
    localparam int SHW = clog2(WIDTH);

    alu_state_e         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;

    logic               accept_s;
    logic               is_mul_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;
    logic [SHW-1:0]     shamt_s;
    logic [WIDTH-1:0]   sum_s, diff_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic               alu_ovf_s;

    assign bus.in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept_s      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;

`ifdef ALU_SEQ_MULT_EN
    logic mul_start_s;

    assign is_mul_s    = (bus.sel == ALU_MULTU);
    assign mul_start_s = accept_s && is_mul_s;
    assign bus.busy    = (state_q == ST_MUL);

    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (mul_start_s),
        .a_i     (bus.op_a),
        .b_i     (bus.op_b),
        .done_o  (mul_done_s),
        .prod_o  (mul_prod_s)
    );
`else
    assign is_mul_s   = 1'b0;
    assign mul_done_s = 1'b0;
    assign mul_prod_s = '0;
    assign bus.busy   = 1'b0;
`endif

    assign shamt_s = bus.op_b[SHW-1:0];
    assign sum_s   = bus.op_a + bus.op_b;
    assign diff_s  = bus.op_a - bus.op_b;

    // Single-cycle operation mux; unknown codes yield zero.
    always_comb begin
        alu_res_s = '0;
        alu_ovf_s = 1'b0;
        case (bus.sel)
            ALU_AND:  alu_res_s = bus.op_a & bus.op_b;
            ALU_OR:   alu_res_s = bus.op_a | bus.op_b;
            ALU_XOR:  alu_res_s = bus.op_a ^ bus.op_b;
            ALU_NOR:  alu_res_s = ~(bus.op_a | bus.op_b);
            ALU_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                            (diff_s[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            ALU_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            ALU_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
            ALU_SLL:  alu_res_s = bus.op_a << shamt_s;
            ALU_SRL:  alu_res_s = bus.op_a >> shamt_s;
            ALU_SRA:  alu_res_s = $signed(bus.op_a) >>> shamt_s;
            default:  alu_res_s = '0;
        endcase
    end

    // Next state: drain the output on out_ready, load single-cycle results or the product.
    always_comb begin
        state_d     = state_q;
        out_valid_d = (out_valid_q && bus.out_ready) ? 1'b0 : out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_d = ST_MUL;
                end else if (accept_s) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_res_s;
                    result_hi_d = '0;
                    zero_d      = (alu_res_s == '0);
                    ovf_d       = alu_ovf_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_prod_s[WIDTH-1:0];
                    result_hi_d = mul_prod_s[2*WIDTH-1:WIDTH];
                    zero_d      = (mul_prod_s[WIDTH-1:0] == '0);
                    ovf_d       = 1'b0;
                end else begin
                    state_d = ST_MUL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule
